// File: rtl/time_display_driver.sv
// rtl/time_display_driver.sv - six-digit multiplexed 7-segment driver for HH:MM:SS time fields
module time_display_driver #(
    parameter int DIV      = 4,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] sec,
    input  logic [6:0] min,
    input  logic [4:0] hr,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_start
);

    localparam int            PW      = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [6:0]    DASH    = 7'h3F;
    localparam logic [6:0]    BLANK   = 7'h7F;

    logic [PW-1:0] pre;
    logic [2:0]    idx;
    logic [6:0]    snap_sec;
    logic [6:0]    snap_min;
    logic [4:0]    snap_hr;

    logic          slot_end;
    logic          frame_end;
    logic          sec_ok, min_ok, hr_ok;
    logic [7:0]    sec_bcd, min_bcd, hr_bcd;
    logic [5:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    // Tens/units by repeated subtraction; only meaningful for 0..59, larger values are dashed anyway.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        for (int k = 0; k < 5; k++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = DASH;
        endcase
        return s;
    endfunction

    assign slot_end  = en && (pre == PRE_MAX);
    assign frame_end = slot_end && (idx == 3'd5);

    always_comb begin
        sec_ok  = (snap_sec <= 7'd59);
        min_ok  = (snap_min <= 7'd59);
        hr_ok   = (snap_hr <= 5'd23);
        sec_bcd = to_bcd(snap_sec);
        min_bcd = to_bcd(snap_min);
        hr_bcd  = to_bcd({2'b00, snap_hr});
        an_nxt  = 6'h3F;
        seg_nxt = BLANK;
        dp_nxt  = 1'b1;
        case (idx)
            3'd0: begin
                an_nxt  = 6'h3E;
                seg_nxt = sec_ok ? seg7(sec_bcd[3:0]) : DASH;
            end
            3'd1: begin
                an_nxt  = 6'h3D;
                seg_nxt = sec_ok ? seg7(sec_bcd[7:4]) : DASH;
            end
            3'd2: begin
                an_nxt  = 6'h3B;
                seg_nxt = min_ok ? seg7(min_bcd[3:0]) : DASH;
            end
            3'd3: begin
                an_nxt  = 6'h37;
                seg_nxt = min_ok ? seg7(min_bcd[7:4]) : DASH;
            end
            3'd4: begin
                an_nxt  = 6'h2F;
                seg_nxt = hr_ok ? seg7(hr_bcd[3:0]) : DASH;
            end
            3'd5: begin
                an_nxt = 6'h1F;
                if (!hr_ok)
                    seg_nxt = DASH;
                else if (LZ_BLANK && (hr_bcd[7:4] == 4'd0))
                    seg_nxt = BLANK;
                else
                    seg_nxt = seg7(hr_bcd[7:4]);
            end
            default: begin
                an_nxt = 6'h3F;
            end
        endcase
        // Colon dots sit on the min-units and hr-units slots and blink with seconds parity.
        if (((idx == 3'd2) || (idx == 3'd4)) && sec_ok && !snap_sec[0])
            dp_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre         <= '0;
            idx         <= 3'd0;
            snap_sec    <= 7'd0;
            snap_min    <= 7'd0;
            snap_hr     <= 5'd0;
            an          <= 6'h3F;
            seg         <= BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
            if (en) begin
                pre <= slot_end ? '0 : pre + 1'b1;
                if (slot_end)
                    idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            if (frame_end) begin
                snap_sec <= sec;
                snap_min <= min;
                snap_hr  <= hr;
            end
            if (en) begin
                an  <= an_nxt;
                seg <= seg_nxt;
                dp  <= dp_nxt;
            end else begin
                an  <= 6'h3F;
                seg <= BLANK;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_time_display_driver.sv
// tb/tb_time_display_driver.sv - scoreboard bench for time_display_driver
module tb_time_display_driver;

    localparam int DIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [6:0] sec = 7'd0;
    logic [6:0] min = 7'd0;
    logic [4:0] hr  = 5'd0;

    logic [6:0] seg0, seg1;
    logic       dp0, dp1;
    logic [5:0] an0, an1;
    logic       fs0, fs1;

    always #5 clk = ~clk;

    time_display_driver #(.DIV(DIV), .LZ_BLANK(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .sec(sec), .min(min), .hr(hr),
        .seg(seg0), .dp(dp0), .an(an0), .frame_start(fs0)
    );

    time_display_driver #(.DIV(DIV), .LZ_BLANK(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .sec(sec), .min(min), .hr(hr),
        .seg(seg1), .dp(dp1), .an(an1), .frame_start(fs1)
    );

    typedef struct packed {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [5:0] prev0 = 6'h3F;
    logic [5:0] prev1 = 6'h3F;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic pop_cmp(input int which, input logic [5:0] a, input logic [6:0] s, input logic d);
        exp_t e;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected_slot dut%0d got an=%0h seg=%0h dp=%0b exp=none", which, a, s, d);
        end else begin
            e = (which == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("slot_dut%0d_an%0h", which, e.an), {a, s, d}, {e.an, e.seg, e.dp});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev0 = 6'h3F;
            prev1 = 6'h3F;
        end else begin
            if (an0 != prev0) begin
                prev0 = an0;
                if (an0 != 6'h3F) pop_cmp(0, an0, seg0, dp0);
            end
            if (an1 != prev1) begin
                prev1 = an1;
                if (an1 != 6'h3F) pop_cmp(1, an1, seg1, dp1);
            end
        end
    end

    task automatic push_frame(input logic [6:0] s0, s1, s2, s3, s4, s5,
                              input logic [5:0] dpm, input logic [6:0] lz5, input bit dup3);
        logic [6:0] s[6];
        exp_t       e;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3; s[4] = s4; s[5] = s5;
        for (int i = 0; i < 6; i++) begin
            e.an  = ~(6'd1 << i);
            e.dp  = dpm[i];
            e.seg = s[i];
            q0.push_back(e);
            if (dup3 && i == 3) q0.push_back(e);
            e.seg = (i == 5) ? lz5 : s[i];
            q1.push_back(e);
            if (dup3 && i == 3) q1.push_back(e);
        end
    endtask

    task automatic set_in(input int s, input int m, input int h);
        sec = 7'(s);
        min = 7'(m);
        hr  = 5'(h);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs0 && n < 200);
        if (!fs0) begin
            checks++;
            failures++;
            $display("FAIL frame_start_timeout got=none exp=pulse");
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dut0"}, {an0, seg0, dp0, fs0}, {6'h3F, 7'h7F, 1'b1, 1'b0});
        chk({tag, "_dut1"}, {an1, seg1, dp1, fs1}, {6'h3F, 7'h7F, 1'b1, 1'b0});
    endtask

    initial begin
        int n;
        rst = 1'b0;
        en  = 1'b1;
        set_in(27, 45, 13);
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");

        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 6'b101011, 7'h7F, 1'b0);
        push_frame(7'h78, 7'h24, 7'h12, 7'h19, 7'h30, 7'h79, 6'b111111, 7'h79, 1'b0);
        rst = 1'b1;
        wait_fs(n);
        chk("fs_period_first", n, 12);

        set_in(28, 45, 13);
        push_frame(7'h00, 7'h24, 7'h12, 7'h19, 7'h30, 7'h79, 6'b101011, 7'h79, 1'b0);
        wait_fs(n);
        chk("fs_period_second", n, 12);

        set_in(29, 45, 13);
        push_frame(7'h10, 7'h24, 7'h12, 7'h19, 7'h30, 7'h79, 6'b111111, 7'h79, 1'b0);
        wait_fs(n);

        // Inputs change during idx 3 of the 13:45:29 frame; it must finish unchanged.
        repeat (3 * DIV) @(negedge clk);
        set_in(29, 46, 14);
        push_frame(7'h10, 7'h24, 7'h02, 7'h19, 7'h19, 7'h79, 6'b111111, 7'h79, 1'b0);
        wait_fs(n);

        set_in(60, 46, 14);
        push_frame(7'h3F, 7'h3F, 7'h02, 7'h19, 7'h19, 7'h79, 6'b111111, 7'h79, 1'b0);
        wait_fs(n);

        set_in(8, 7, 24);
        push_frame(7'h00, 7'h40, 7'h78, 7'h40, 7'h3F, 7'h3F, 6'b101011, 7'h3F, 1'b0);
        wait_fs(n);

        set_in(59, 59, 5);
        push_frame(7'h10, 7'h12, 7'h10, 7'h12, 7'h12, 7'h40, 6'b111111, 7'h7F, 1'b0);
        wait_fs(n);

        set_in(0, 60, 23);
        push_frame(7'h40, 7'h40, 7'h3F, 7'h3F, 7'h30, 7'h24, 6'b101011, 7'h24, 1'b0);
        wait_fs(n);

        set_in(14, 30, 9);
        push_frame(7'h19, 7'h79, 7'h40, 7'h30, 7'h10, 7'h40, 6'b101011, 7'h7F, 1'b1);
        wait_fs(n);

        // Pause while the min-tens slot is on screen; it reappears on resume.
        repeat (3 * DIV + 1) @(negedge clk);
        #1 en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("paused_blank_%0d", k), {an0, seg0, dp0, fs0}, {6'h3F, 7'h7F, 1'b1, 1'b0});
        end
        en = 1'b1;

        set_in(1, 0, 4);
        push_frame(7'h79, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40, 6'b111111, 7'h7F, 1'b0);
        wait_fs(n);

        repeat (4 * DIV + 1) @(negedge clk);
        #1 rst = 1'b0;
        #1 chk_reset_vals("async_reset");
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        chk_reset_vals("held_reset");

        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 6'b101011, 7'h7F, 1'b0);
        push_frame(7'h79, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40, 6'b111111, 7'h7F, 1'b0);
        rst = 1'b1;
        wait_fs(n);
        chk("fs_period_after_reset", n, 12);
        wait_fs(n);
        chk("fs_period_after_reset2", n, 12);
        #1 en = 1'b0;
        repeat (4) @(negedge clk);
        chk("queue0_drained", q0.size(), 0);
        chk("queue1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/time_display_driver.md
Name: time_display_driver

Overview:
- Consumes the binary time fields produced by digital_clock (sec, min, hr) and drives a 6-digit, multiplexed, common-anode 7-segment display (HH MM SS).
- Takes a coherent snapshot of the time once per scan frame, converts each field to two BCD digits, and time-multiplexes the digits using a prescaled scan counter.
- Drives the colon dots, which blink on seconds parity.
- Sits between digital_clock and the board-level display pins.

Parameters:
- DIV, 4: clock cycles per digit slot (≥2); one frame = 6*DIV cycles.
- LZ_BLANK, 0: when 1, hour-tens digit blanks when it is 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  scan enable; 0 freezes scan and blanks display.
- sec  input  7  binary seconds, valid 0..59.
- min  input  7  binary minutes, valid 0..59.
- hr  input  5  binary hours, valid 0..23.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal-point/colon drive, active-low.
- an  output  6  digit anodes, one-hot active-low; an[0]=sec units ... an[5]=hr tens.
- frame_start  output  1  one-cycle pulse at start of each frame.

Behaviour:
- Reset (rst=0, async), all state and outputs take these values:
  - pre=0, idx=0, snap_sec/min/hr=0.
  - an=6'b111111, seg=7'h7F, dp=1, frame_start=0.
- Prescaler:
  - When en=1, pre counts 0..DIV-1 and wraps.
  - On pre==DIV-1, idx advances 0→1→…→5→0.
  - When en=0, pre and idx hold.
- Digit map (idx): 0=sec units, 1=sec tens, 2=min units, 3=min tens, 4=hr units, 5=hr tens.
- Snapshot:
  - Loaded on the edge where en=1, pre==DIV-1 and idx==5 (the frame boundary).
  - Inputs are ignored at all other times, so changes mid-frame never tear the display.
  - Until the first boundary after reset, the display shows the reset snapshot 00:00:00.
- frame_start: registered; equals 1 exactly in the cycle following a snapshot load, i.e. while idx==0 and pre==0; otherwise 0.
- Output register:
  - an, seg and dp are registered from the current (idx, snap).
  - They change one cycle after idx changes; this latency is fixed and uniform.
  - When en=0, the next edge loads an=3F, seg=7F, dp=1.
  - On re-enable, scanning resumes at the held idx/pre.
- BCD split:
  - tens = value/10, units = value%10, by compare-subtract.
  - Combinational on snap, so no extra latency.
- Segment codes (active-low, hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - dash=3F, blank=7F.
- Range checks:
  - snap_sec>59 → both sec digits dash. snap_min>59 → both min digits dash. snap_hr>23 → both hr digits dash.
  - Fields are checked independently.
- Leading zero: with LZ_BLANK=1 and a valid hr<10, the hr-tens slot shows blank (7F).
- Colon (dp):
  - dp=0 during idx 2 and 4 slots when snap_sec is valid and even.
  - dp=1 in all other cases.
- Reset mid-frame: outputs go to reset values immediately (asynchronously); scanning restarts at idx 0 after release.

Test Plan:
- Reset and first frame (DIV=2): hold rst=0 → an=3F, seg=7F, dp=1, frame_start=0. Release with en=1 → first frame shows seg 40 in all six slots; an walks 3E,3D,3B,37,2F,1F, each for 2 cycles, one cycle behind idx; frame_start pulses every 12 cycles.
- Decode: hr=13, min=45, sec=27 before a boundary → next frame seg sequence:
  - an[0]=78, an[1]=24, an[2]=12, an[3]=19, an[4]=30, an[5]=79.
  - dp=1 throughout (odd seconds).
- Colon blink: sec=28 → dp=0 only in an[2] and an[4] slots. sec=29 → dp=1 in all slots.
- Tear-freedom: change min 45→46 during idx 3 → current frame still shows 45; next frame shows 46.
- Range and blanking:
  - sec=60 → sec slots 3F, dp=1. hr=24 → hr slots 3F.
  - With LZ_BLANK=1, hr=5 → an[5] slot seg=7F and an[4] slot seg=12.
- Enable and reset mid-frame:
  - en=0 at idx 3 → next edge an=3F, seg=7F; idx/pre hold. en=1 → resumes the same slot for the remaining cycles.
  - rst=0 at idx 4 → outputs go to reset values immediately; idx=0 after release.
